data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Data-memory controller that sits directly downstream of the core's data port (data_ce/data_we/data_addr/data_o/data_i). It holds a word-organised on-chip data RAM and serves byte, halfword and word loads and stores, with sign or zero extension on loads. Each access runs through a small FSM with programmable wait states and signals completion with a one-cycle ready pulse. Misaligned and out-of-range accesses are flagged as errors.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
WAIT_CYCLES, 1, extra wait-state cycles inserted before every access; 0..15 legal.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
data_ce_i  input  1  read request
data_we_i  input  1  write request; takes priority over data_ce_i when both are high
data_addr_i  input  32  byte address
data_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
data_size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
data_unsigned_i  input  1  load extension: 1 zero-extend, 0 sign-extend
data_o  output  32  load result, right-aligned and extended
data_ready_o  output  1  one-cycle completion pulse
data_err_o  output  1  error flag, valid while data_ready_o=1

Behaviour:
- Reset: state=IDLE, wait counter=0, data_o=0, data_ready_o=0, data_err_o=0. RAM contents are not affected by rst.
- Reset has priority in every state. If rst is high during ACCESS, the write is suppressed. A request that was in flight is dropped and gets no ready pulse.
- A request exists when data_ce_i | data_we_i is high.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: on a request, capture addr, wdata, we, size and unsigned into internal registers. Go to WAIT (counter=WAIT_CYCLES-1) if WAIT_CYCLES>0, otherwise go to ACCESS. Inputs are sampled only at this acceptance edge.
  - WAIT: decrement the counter; go to ACCESS when the counter reaches 0.
  - ACCESS: check the captured request, then either perform the RAM read or write or record an error. Go to DONE.
  - DONE: data_ready_o=1 for exactly this cycle, then go to IDLE.
- Latency: the ready pulse arrives WAIT_CYCLES+2 cycles after the cycle in which the request was accepted in IDLE.
- The requester holds its request until it sees ready. Requests in WAIT, ACCESS or DONE are ignored. A request still held in the DONE cycle is re-accepted in the next IDLE cycle, so the requester must drop it in the ready cycle.
- data_o and data_err_o are registered. They update on entry to DONE and hold until the next DONE or reset. On a write completion, data_o=0.
- Error conditions: half access with addr[0]=1; word access with addr[1:0]≠0; size=11; or addr[31:ADDR_WIDTH+2]≠0.
  - On error: no RAM access, data_err_o=1, data_o=0.
- RAM index = addr[ADDR_WIDTH+1:2]. Lane = addr[1:0].
- Byte store: write data_i[7:0] into lane addr[1:0] only.
- Half store: write data_i[15:0] into bytes addr[1]*2 and addr[1]*2+1 only.
- Word store: write all 4 bytes.
- Byte load: select the lane and extend bit 7 (or zero-extend if data_unsigned_i=1).
- Half load: select the half and extend bit 15 (or zero-extend if data_unsigned_i=1).
- Word load: return the word unchanged.
- Little-endian byte order.

Test Plan:
- WAIT_CYCLES=1: write word 0xDEADBEEF to addr 0x10, then read word at 0x10. Required: each ready pulse arrives exactly 3 cycles after acceptance, lasts 1 cycle, err=0, data_o=0xDEADBEEF.
- Starting from word 0xDEADBEEF at 0x10, store byte 0x5A at addr 0x11, then read word 0x10. Required: 0xDEAD5AEF.
- Sub-word loads: signed byte at 0x13 gives 0xFFFFFFDE; unsigned byte at 0x13 gives 0x000000DE; signed half at 0x12 gives 0xFFFFDEAD; unsigned half at 0x10 gives 0x00005AEF.
- Errors:
  - Word read at 0x12 gives err=1, data_o=0.
  - Half write at 0x11 gives err=1 and the RAM is unchanged (re-reading 0x10 still returns 0xDEAD5AEF).
  - Size=11 gives err=1.
  - Addr 0x00001000 with ADDR_WIDTH=10 gives err=1.
- Reset mid-operation: accept a word write of 0x12345678 to 0x20, then assert rst during the ACCESS cycle. Required: no ready pulse, all outputs 0, and a later read of 0x20 still returns the earlier value.
- WAIT_CYCLES=0 with back-to-back requests: ready arrives 2 cycles after acceptance. A request held through DONE is re-accepted in the following IDLE cycle. A request asserted during WAIT or ACCESS is ignored.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Data-port bus between the core (master) and the data-memory controller (slave).
interface data_mem_ctrl_if;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_i;
    logic [1:0]  data_size_i;
    logic        data_unsigned_i;
    logic [31:0] data_o;
    logic        data_ready_o;
    logic        data_err_o;

    modport master (
        output data_ce_i, data_we_i, data_addr_i, data_i, data_size_i, data_unsigned_i,
        input  data_o, data_ready_o, data_err_o
    );

    modport slave (
        input  data_ce_i, data_we_i, data_addr_i, data_i, data_size_i, data_unsigned_i,
        output data_o, data_ready_o, data_err_o
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word-organised on-chip RAM serving byte/half/word
// loads and stores with sign/zero extension, programmable wait states and a
// one-cycle ready pulse. Misaligned and out-of-range accesses report an error.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    // Request as captured at the acceptance edge; the bus is not looked at again.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic                  acc_err;
    logic                  wr_en;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic [31:0]           rd_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           load_val;

    assign idx     = req_q.addr[ADDR_WIDTH+1:2];
    assign lane    = req_q.addr[1:0];
    assign rd_word = mem[idx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

    // Flag misaligned, reserved-size and out-of-range requests.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        acc_err = 1'b0;
        case (req_q.size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = lane[0];
            2'b10:   acc_err = (lane != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if ((req_q.addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
            acc_err = 1'b1;
        end
    end

    // Steer store data onto byte lanes and extend load data from its lane.
    always_comb begin
        wr_be    = 4'b0000;
        wr_data  = 32'd0;
        load_val = rd_word;
        case (req_q.size)
            2'b00: begin
                wr_be    = 4'b0001 << lane;
                wr_data  = {4{req_q.wdata[7:0]}};
                load_val = req_q.uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                wr_be    = lane[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{req_q.wdata[15:0]}};
                load_val = req_q.uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            2'b10: begin
                wr_be    = 4'b1111;
                wr_data  = req_q.wdata;
                load_val = rd_word;
            end
            default: begin
                wr_be    = 4'b0000;
                wr_data  = 32'd0;
                load_val = 32'd0;
            end
        endcase
    end

    // A store lands only in ACCESS, only when legal, and never while rst is high.
    assign wr_en = (state_q == S_ACCESS) && req_q.we && !acc_err && !rst;

    // Byte-enabled RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately left out of reset; its contents survive rst and it maps onto plain RAM cells.
        if (wr_en) begin
            if (wr_be[0]) mem[idx][7:0]   <= wr_data[7:0];
            if (wr_be[1]) mem[idx][15:8]  <= wr_data[15:8];
            if (wr_be[2]) mem[idx][23:16] <= wr_data[23:16];
            if (wr_be[3]) mem[idx][31:24] <= wr_data[31:24];
        end
    end

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.data_ce_i || bus.data_we_i) begin
                    req_d.we    = bus.data_we_i;
                    req_d.size  = bus.data_size_i;
                    req_d.uns   = bus.data_unsigned_i;
                    req_d.addr  = bus.data_addr_i;
                    req_d.wdata = bus.data_i;
                    if (WAIT_CYCLES != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                ready_d = 1'b1;
                if (acc_err) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    rdata_d = req_q.we ? 32'd0 : load_val;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority in every state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.data_o       = rdata_q;
    assign bus.data_ready_o = ready_q;
    assign bus.data_err_o   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (WAIT_CYCLES=0 and 1) compared every
// cycle against a byte-array transaction model, plus directed literal checks.
module tb_data_mem_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_ctrl_if if0 ();
    data_mem_ctrl_if if1 ();

    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got 0x%08h, required 0x%08h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wait_of [2] = '{0, 1};
    logic [7:0]  mm [2][64];
    int          ready_at [2] = '{-1, -1};
    int          free_at [2] = '{0, 0};
    logic [31:0] hold_data [2] = '{32'd0, 32'd0};
    logic        hold_err [2] = '{1'b0, 1'b0};
    logic [31:0] pend_data [2];
    logic        pend_err [2];
    logic        pend_we [2];
    logic [31:0] pend_addr [2];
    logic [31:0] pend_wdata [2];
    int          pend_nb [2];
    bit          model_on = 0;

    // Work out what a request will return and what it will store.
    task automatic predict(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns);
        int          nb;
        logic [31:0] v;
        logic        e;
        nb = 1 << sz;
        e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
             (a >= 32'(4 << AW));
        v  = 32'd0;
        if (!e) begin
            if (a + nb > 64) $fatal(1, "FAIL stimulus: address 0x%08h outside model window", a);
            for (int i = 0; i < nb; i++) v = v | (32'(mm[d][a + i]) << (8 * i));
            if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        pend_err[d]   = e;
        pend_data[d]  = (e || we) ? 32'd0 : v;
        pend_we[d]    = we;
        pend_addr[d]  = a;
        pend_wdata[d] = wd;
        pend_nb[d]    = nb;
    endtask

    task automatic model_cycle(input int d, input logic ce, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                               input logic [31:0] dout, input logic rdy, input logic e);
        bit is_done;
        is_done = (cyc == ready_at[d]);
        if (is_done) begin
            hold_data[d] = pend_data[d];
            hold_err[d]  = pend_err[d];
            if (pend_we[d] && !pend_err[d])
                for (int i = 0; i < pend_nb[d]; i++) mm[d][pend_addr[d] + i] = pend_wdata[d][8 * i +: 8];
        end
        if (model_on) begin
            check(d ? "dut1 ready" : "dut0 ready", 32'(rdy), 32'(is_done));
            check(d ? "dut1 data_o" : "dut0 data_o", dout, hold_data[d]);
            check(d ? "dut1 err" : "dut0 err", 32'(e), 32'(hold_err[d]));
        end
        if (rst) begin
            ready_at[d]  = -1;
            free_at[d]   = cyc + 1;
            hold_data[d] = 32'd0;
            hold_err[d]  = 1'b0;
        end else if (cyc >= free_at[d] && (ce || we)) begin
            predict(d, we, a, wd, sz, uns);
            ready_at[d] = cyc + wait_of[d] + 2;
            free_at[d]  = ready_at[d] + 1;
        end
    endtask

    // Compare process: one look per cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            model_cycle(0, if0.data_ce_i, if0.data_we_i, if0.data_addr_i, if0.data_i, if0.data_size_i,
                        if0.data_unsigned_i, if0.data_o, if0.data_ready_o, if0.data_err_o);
            model_cycle(1, if1.data_ce_i, if1.data_we_i, if1.data_addr_i, if1.data_i, if1.data_size_i,
                        if1.data_unsigned_i, if1.data_o, if1.data_ready_o, if1.data_err_o);
            if (rst) model_on = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic ce, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        if (d == 0) begin
            if0.data_ce_i = ce; if0.data_we_i = we; if0.data_addr_i = a;
            if0.data_i = wd; if0.data_size_i = sz; if0.data_unsigned_i = uns;
        end else begin
            if1.data_ce_i = ce; if1.data_we_i = we; if1.data_addr_i = a;
            if1.data_i = wd; if1.data_size_i = sz; if1.data_unsigned_i = uns;
        end
    endtask

    task automatic sample(input int d, output logic rdy, output logic [31:0] dout, output logic e);
        if (d == 0) begin
            rdy = if0.data_ready_o; dout = if0.data_o; e = if0.data_err_o;
        end else begin
            rdy = if1.data_ready_o; dout = if1.data_o; e = if1.data_err_o;
        end
    endtask

    // One handshake: hold the request until ready, drop it in the ready cycle.
    task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                       output logic [31:0] dout, output logic e);
        int   n;
        logic rdy;
        @(posedge clk); #1;
        drive(d, we ? 1'($urandom_range(0, 1)) : 1'b1, we, a, wd, sz, uns);
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(posedge clk); #1;
            n++;
            sample(d, rdy, dout, e);
            if (!rdy && scramble) drive(d, 1'b1, 1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom));
        end
        drive(d, 1'b0, 1'b0, $urandom, $urandom, 2'($urandom), 1'($urandom));
        check(d ? "dut1 latency" : "dut0 latency", n, wait_of[d] + 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dout;
        logic        e;
        logic        rdy;
        int          pulses;
        int          first;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sample(1, rdy, dout, e);
        check("reset ready", 32'(rdy), 0);
        check("reset data_o", dout, 0);
        check("reset err", 32'(e), 0);

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) txn(d, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0, dout, e);

        // Directed sequence on the WAIT_CYCLES=1 instance.
        txn(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, dout, e);
        check("write word data_o", dout, 0);
        check("write word err", 32'(e), 0);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, dout, e);
        check("read word", dout, 32'hDEADBEEF);
        check("read word err", 32'(e), 0);
        txn(1, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, 1'b0, dout, e);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, dout, e);
        check("byte store merge", dout, 32'hDEAD5AEF);
        txn(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, dout, e);
        check("signed byte", dout, 32'hFFFFFFDE);
        txn(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, dout, e);
        check("unsigned byte", dout, 32'h000000DE);
        txn(1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, dout, e);
        check("signed half", dout, 32'hFFFFDEAD);
        txn(1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, dout, e);
        check("unsigned half", dout, 32'h00005AEF);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, dout, e);
        check("misaligned word err", 32'(e), 1);
        check("misaligned word data", dout, 0);
        txn(1, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 1'b0, dout, e);
        check("misaligned half write err", 32'(e), 1);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, dout, e);
        check("ram unchanged after err", dout, 32'hDEAD5AEF);
        txn(1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, dout, e);
        check("reserved size err", 32'(e), 1);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0, 1'b0, dout, e);
        check("out of range err", 32'(e), 1);
        check("out of range data", dout, 0);

        // Reset while the write is in ACCESS: no ready, no store.
        txn(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, dout, e);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            sample(1, rdy, dout, e);
            if (rdy) pulses++;
            if (k == 0) begin
                check("post-reset data_o", dout, 0);
                check("post-reset err", 32'(e), 0);
            end
            @(posedge clk); #1;
        end
        check("no ready after reset", pulses, 0);
        txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, dout, e);
        check("write suppressed by reset", dout, 32'hCAFEF00D);

        // WAIT_CYCLES=0: back-to-back and a request held through DONE.
        txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h89ABCDEF, 1'b0, dout, e);
        txn(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, dout, e);
        check("dut0 signed byte", dout, 32'hFFFFFFCD);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            sample(0, rdy, dout, e);
            if (rdy) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("held request pulses", pulses, 3);
        check("held request first pulse", first, 2);
        check("held request data", dout, 32'h89ABCDEF);

        // Random traffic on both instances, model-checked every cycle.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_1000;
            else if (sz == 2'b10) a = 32'($urandom_range(0, 61));
            else a = 32'($urandom_range(0, 62));
            if (sz == 2'b00) a = 32'($urandom_range(0, 63));
            txn(i % 2, 1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom), dout, e);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
